vga_sync_gen: RTL
=================

# vga_sync_gen

Raster timing generator for the character display path. Produces the `Columnas`/`Filas` pixel coordinates consumed by the character ROM stage, plus `HSYNC`, `VSYNC` and `Video_on` to the VGA output pins. The default parameters give 640x480 at 60 Hz from a 25 MHz pixel rate. An optional delay line re-times the sync and blanking outputs so they line up with the registered ROM pixel bit.

## Interface
Parameters:
- `H_VIS`, 640: visible columns.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_VIS`, 480: visible rows.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.
- `ALIGN`, 1: CLK cycles of sync/blank delay; used only with `VGA_SYNC_ALIGN_EN`; range 1–4.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST_N`  in  1  asynchronous reset, active-low.
- `Pix_en`  in  1  pixel tick; counters advance only when high.
- `Columnas`  out  11  horizontal counter, 0..H_TOTAL-1.
- `Filas`  out  10  vertical counter, 0..V_TOTAL-1.
- `HSYNC`  out  1  horizontal sync, active-low.
- `VSYNC`  out  1  vertical sync, active-low.
- `Video_on`  out  1  high inside the visible area.
- `Fin_cuadro`  out  1  one-CLK pulse at frame wrap.

## Operation
- Derived totals:
  - H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800 by default).
  - V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525 by default).
- Counter behaviour on a CLK edge with `Pix_en`=1:
  - `Columnas` increments.
  - At H_TOTAL-1, `Columnas` wraps to 0 and `Filas` increments.
  - When `Filas` is at V_TOTAL-1 and `Columnas` wraps, `Filas` wraps to 0.
- With `Pix_en`=0, every counter and output holds, except the align pipeline (see Configuration).
- Decodes, applied to the counter values:
  - `Video_on` = (Columnas < H_VIS) && (Filas < V_VIS).
  - `HSYNC` = 0 for Columnas in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], i.e. 656..751 by default.
  - `VSYNC` = 0 for Filas in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], i.e. 490..491 by default.
- Decodes are registered. They are computed from the counters' next values, so without the macro they refer to the same coordinates as `Columnas`/`Filas` in the same cycle.
- `Fin_cuadro`:
  - Goes high for exactly one CLK, in the cycle where the counters first show (0,0) after wrapping from (H_TOTAL-1, V_TOTAL-1).
  - Does not pulse on exit from reset.
- Arithmetic is unsigned. Counter widths are fixed at 11 and 10 bits; parameter sets must keep H_TOTAL ≤ 2048 and V_TOTAL ≤ 1024.

## Timing
- Reset values: `Columnas`=0, `Filas`=0, `HSYNC`=1, `VSYNC`=1, `Video_on`=0, `Fin_cuadro`=0. All align-pipeline stages reset to the same inactive values.
- First `Pix_en` after reset release:
  - Counters go to (1,0).
  - `Video_on`=1 for that coordinate. Coordinate (0,0) is shown blanked in the first frame only.
- Counter latency: one CLK from the `Pix_en` edge.
- Reset asserted mid-frame forces all reset values immediately. On release, counting restarts from (0,0) with no `Fin_cuadro` pulse.
- `Pix_en` tied high: one pixel per CLK.
- `Pix_en` toggling every other cycle: each coordinate holds for two CLKs.

## Configuration
- Macro: `VGA_SYNC_ALIGN_EN`.
- Defined:
  - `HSYNC`, `VSYNC`, `Video_on` and `Fin_cuadro` pass through an `ALIGN`-stage shift register clocked on every CLK. The shift is not gated by `Pix_en`, because the ROM latency is counted in CLK cycles.
  - `Columnas`/`Filas` are not delayed.
  - Result: these outputs lag the coordinates by exactly `ALIGN` CLKs, matching the registered ROM `Data`.
- Undefined: no pipeline; zero relative latency as described in Operation.

## Test plan
- Reset: hold `RST_N`=0 with `Pix_en`=1 → `Columnas`=0, `Filas`=0, `HSYNC`=1, `VSYNC`=1, `Video_on`=0, `Fin_cuadro`=0.
- Line wrap, `Pix_en`=1: after (799,0) the next cycle shows (0,1). `HSYNC`=0 for exactly 96 CLKs, at Columnas 656..751. `Video_on`=0 for Columnas 640..799.
- Frame wrap: after (799,524) the next cycle shows (0,0) with `Fin_cuadro`=1 for 1 CLK. `VSYNC`=0 for Filas 490..491 (1600 CLKs). Frame period is 420000 CLKs.
- `Pix_en` alternating 1/0: each coordinate is stable for 2 CLKs. Line period is 1600 CLKs. `Fin_cuadro` is still 1 CLK wide.
- `VGA_SYNC_ALIGN_EN`, `ALIGN`=2: `HSYNC` falls 2 CLKs after `Columnas`=656. `Video_on` falls 2 CLKs after `Columnas`=640.
- Reset pulse at (300,200): outputs return to reset values asynchronously. After release, counting restarts at (0,0), no `Fin_cuadro` pulse, and the next frame wrap behaves normally.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster counters with registered HSYNC/VSYNC/Video_on decodes.
// Define VGA_SYNC_ALIGN_EN to delay sync/blank/frame outputs by ALIGN CLKs.
module vga_sync_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int ALIGN  = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Pix_en,
    output logic [10:0] Columnas,
    output logic [9:0]  Filas,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        Video_on,
    output logic        Fin_cuadro
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VISW = 11'(H_VIS);
    localparam logic [10:0] HS_BEG = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END = 11'(H_VIS + H_FP + H_SYNC - 1);

    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VISW = 10'(V_VIS);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);

    if (ALIGN < 1 || ALIGN > 4) begin : g_bad_align
        $error("vga_sync_gen: ALIGN must be in 1..4");
    end

    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        vid_q, vid_d;
    logic        fin_q, fin_d;

    // Decodes look at the next coordinate so they line up with the counters.
    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        vid_d = vid_q;
        fin_d = 1'b0;
        if (Pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d   = '0;
                    fin_d = 1'b1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 11'd1;
            end
            vid_d = (h_d < H_VISW) && (v_d < V_VISW);
            hs_d  = !((h_d >= HS_BEG) && (h_d <= HS_END));
            vs_d  = !((v_d >= VS_BEG) && (v_d <= VS_END));
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_q   <= '0;
            v_q   <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            vid_q <= 1'b0;
            fin_q <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            vid_q <= vid_d;
            fin_q <= fin_d;
        end
    end

    assign Columnas = h_q;
    assign Filas    = v_q;

`ifdef VGA_SYNC_ALIGN_EN
    // Shifts every CLK: ROM latency is counted in clocks, not pixels.
    logic [3:0] pipe_q [ALIGN];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < ALIGN; i++) begin
                pipe_q[i] <= 4'b1100;
            end
        end else begin
            pipe_q[0] <= {hs_q, vs_q, vid_q, fin_q};
            for (int i = 1; i < ALIGN; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign {HSYNC, VSYNC, Video_on, Fin_cuadro} = pipe_q[ALIGN-1];
`else
    assign HSYNC      = hs_q;
    assign VSYNC      = vs_q;
    assign Video_on   = vid_q;
    assign Fin_cuadro = fin_q;
`endif

endmodule
